// File: rtl/alu8_sequencer.sv
// alu8_sequencer: runs one 8-bit ALU operation as two 4-bit passes through
// an external ALU slice. The low nibble goes first and its carry/borrow is
// chained into the high nibble. The block assembles the 8-bit result and the
// Z/C/H flags.
module alu8_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_h,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  output logic       alu_c,
  input  logic [3:0] alu_out,
  input  logic       alu_z,
  input  logic       alu_c_out
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] a_hi_q, a_hi_d;
  logic [3:0] b_hi_q, b_hi_d;
  logic [2:0] op_q, op_d;
  logic       lo_z_q, lo_z_d;
  logic [7:0] result_q, result_d;
  logic       flag_z_q, flag_z_d;
  logic       flag_c_q, flag_c_d;
  logic       flag_h_q, flag_h_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic       alu_c_q, alu_c_d;
  logic       accept;

  // Next state, operand capture, nibble captures and the next value of the
  // slice drive. The slice drive is computed from the next state, so during
  // LO and HI it comes straight from flops.
  always_comb begin
    state_d  = state_q;
    a_hi_d   = a_hi_q;
    b_hi_d   = b_hi_q;
    op_d     = op_q;
    lo_z_d   = lo_z_q;
    result_d = result_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    flag_h_d = flag_h_q;
    alu_a_d  = 4'h0;
    alu_b_d  = 4'h0;
    alu_op_d = 3'd0;
    alu_c_d  = 1'b0;
    accept   = 1'b0;

    case (state_q)
      IDLE: accept = start;
      LO: begin
        state_d       = HI;
        result_d[3:0] = alu_out;
        flag_h_d      = ~op_q[2] & alu_c_out;
        lo_z_d        = alu_z;
        alu_a_d       = a_hi_q;
        alu_b_d       = b_hi_q;
        // The high nibble always runs carry-chained arithmetic (adc/sbc).
        // Logic ops pass through unchanged.
        alu_op_d      = op_q[2] ? op_q : {1'b0, op_q[1], 1'b1};
        alu_c_d       = ~op_q[2] & alu_c_out;
      end
      HI: begin
        state_d       = DONE;
        result_d[7:4] = alu_out;
        flag_c_d      = ~op_q[2] & alu_c_out;
        flag_z_d      = alu_z & lo_z_q;
      end
      DONE: begin
        accept = start;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The low nibble is driven straight from the inputs on the accept edge.
    // Only the high nibbles need to be held for the HI pass.
    if (accept) begin
      state_d  = LO;
      a_hi_d   = a[7:4];
      b_hi_d   = b[7:4];
      op_d     = op;
      alu_a_d  = a[3:0];
      alu_b_d  = b[3:0];
      alu_op_d = op[2] ? op : {1'b0, op[1], 1'b1};
      alu_c_d  = ~op[2] & op[0] & c_in;
    end

    busy_d = (state_d == LO) || (state_d == HI);
    done_d = (state_d == DONE);
  end

  // State and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_hi_q   <= 4'h0;
      b_hi_q   <= 4'h0;
      op_q     <= 3'd0;
      lo_z_q   <= 1'b0;
      result_q <= 8'h00;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_h_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      alu_a_q  <= 4'h0;
      alu_b_q  <= 4'h0;
      alu_op_q <= 3'd0;
      alu_c_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_hi_q   <= a_hi_d;
      b_hi_q   <= b_hi_d;
      op_q     <= op_d;
      lo_z_q   <= lo_z_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      flag_h_q <= flag_h_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      alu_c_q  <= alu_c_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
  assign flag_h = flag_h_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;
  assign alu_c  = alu_c_q;

endmodule

// File: doc/alu8_sequencer.md
ALU8_SEQUENCER -- requirements
Module: alu8_sequencer

Interface
REQ-001 SHALL have no parameters; datapath fixed at 8 bits, processed as two 4-bit nibbles through one external 4-bit ALU slice.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 op  input  3  operation: 0 add, 1 adc, 2 sub, 3 sbc, 4 and, 5 xor, 6 or, 7 cp (complement A).
REQ-006 a, b  input  8 each  operands; captured on accepted start.
REQ-007 c_in  input  1  carry/borrow in for adc/sbc; captured on accepted start.
REQ-008 busy  output  1  high in LO and HI states.
REQ-009 done  output  1  one-cycle pulse in DONE state.
REQ-010 result  output  8  assembled result; held until the next accepted start.
REQ-011 flag_z, flag_c, flag_h  output  1 each  zero, carry/borrow out of bit 7, carry/borrow out of bit 3.
REQ-012 alu_a, alu_b  output  4 each  nibble operands to the ALU slice.
REQ-013 alu_op  output  3  op code to the ALU slice, same encoding as op.
REQ-014 alu_c  output  1  carry/borrow in to the ALU slice.
REQ-015 alu_out  input  4  ALU slice result, combinational from alu_* in the same cycle.
REQ-016 alu_z, alu_c_out  input  1 each  ALU slice zero and carry/borrow out, same cycle.

Function
REQ-017 SHALL implement FSM states IDLE, LO, HI, DONE; IDLE + start -> LO; LO -> HI; HI -> DONE; DONE + start -> LO; DONE without start -> IDLE.
REQ-018 SHALL ignore start in LO and HI; no capture, no effect on the current operation.
REQ-019 On accepted start SHALL register a, b, op, c_in; later changes to these inputs SHALL NOT affect the operation in flight.
REQ-020 alu_a/alu_b/alu_op/alu_c SHALL be driven from registers: a[3:0]/b[3:0] in LO, a[7:4]/b[7:4] in HI, all zero in IDLE and DONE.
REQ-021 Low-nibble alu_op mapping: add -> adc with alu_c=0; sub -> sbc with alu_c=0; adc/sbc -> same op with alu_c=captured c_in; ops 4-7 unchanged with alu_c=0.
REQ-022 High-nibble alu_op mapping: add/adc -> adc, sub/sbc -> sbc, with alu_c=captured low-nibble alu_c_out; ops 4-7 unchanged with alu_c=0.
REQ-023 At end of LO SHALL capture alu_out into result[3:0], alu_c_out into flag_h, alu_z into an internal low-zero bit.
REQ-024 At end of HI SHALL capture alu_out into result[7:4], alu_c_out into flag_c, and set flag_z = alu_z AND low-zero.
REQ-025 For ops 4-7, flag_c and flag_h SHALL be 0.
REQ-026 Latency: start accepted at edge N -> LO in cycle N+1, HI in N+2, done=1 in N+3; result/flags valid from N+3 onward.
REQ-027 result and flags SHALL update only at the LO/HI capture edges; they SHALL hold their values in IDLE and DONE.
REQ-028 Back-to-back: start in DONE SHALL be accepted; done pulses once per operation, never two consecutive cycles.
REQ-029 busy SHALL be a registered state decode: 1 exactly in LO and HI.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE; result=0x00, flag_z=0, flag_c=0, flag_h=0, busy=0, done=0, alu_* outputs=0.
REQ-031 Reset in LO or HI SHALL abort the operation with no done pulse; rst overrides a simultaneous start.

Verification
REQ-032 add a=0x3A b=0x0F -> LO drives alu_op=1 alu_c=0; done at N+3; result=0x49, flag_h=1, flag_c=0, flag_z=0.
REQ-033 sub a=0x10 b=0x01 -> result=0x0F, flag_h=1, flag_c=0, flag_z=0.
REQ-034 adc a=0xFF b=0x00 c_in=1 -> result=0x00, flag_h=1, flag_c=1, flag_z=1.
REQ-035 and a=0xF0 b=0x0F -> result=0x00, flag_z=1, flag_c=0, flag_h=0; alu_c=0 in LO and HI.
REQ-036 start during LO with different a/b -> ignored; first result unaffected; single done pulse; start in DONE -> new op, done again 3 cycles later.
REQ-037 rst asserted during HI -> next cycle IDLE, busy=0, result=0x00, all flags 0, no done pulse.
